// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider_if
// Description : Start/busy/done handshake and operand/result bundle for the
//               sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_restoring_divider_if #(
    parameter int W = 16
);
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           busy;
    logic           done;
    logic           div_zero;
    logic           ovf;

    modport master (
        output start, dividend, divisor,
        input  q, r, busy, done, div_zero, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output q, r, busy, done, div_zero, ovf
    );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider
// Description : Unsigned 2W/W restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    seq_restoring_divider_if.slave bus
);
    localparam int            CW     = $clog2(2*W);
    localparam logic [CW-1:0] C_LAST = CW'(2*W-1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_dvd;
    logic [W-1:0]   r_dvs;
    logic [W-1:0]   r_p;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_r;
    logic           r_busy;
    logic           r_done;
    logic           r_div_zero;
    logic           r_ovf;

    logic [W:0]     w_p_shift;
    logic [W-1:0]   w_p_sub;
    logic [W-1:0]   w_p_next;
    logic           w_qbit;

    // The restored remainder is always below the divisor, so it fits in W
    // bits; only the shifted value needs the extra carry bit for the compare.
    assign w_p_shift = {r_p, r_dvd[2*W-1]};
    assign w_qbit    = (w_p_shift >= {1'b0, r_dvs});
    assign w_p_sub   = w_p_shift[W-1:0] - r_dvs;
    assign w_p_next  = w_qbit ? w_p_sub : w_p_shift[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_p        <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dvd <= bus.dividend;
                        r_dvs <= bus.divisor;
                        if (bus.divisor == '0) begin
                            r_q        <= '1;
                            r_r        <= bus.dividend[W-1:0];
                            r_div_zero <= 1'b1;
                            r_ovf      <= 1'b0;
                            r_state    <= S_FIN;
                        end else if (bus.dividend[2*W-1:W] >= bus.divisor) begin
                            r_q        <= '1;
                            r_r        <= '0;
                            r_div_zero <= 1'b0;
                            r_ovf      <= 1'b1;
                            r_state    <= S_FIN;
                        end else begin
                            r_div_zero <= 1'b0;
                            r_ovf      <= 1'b0;
                            r_p        <= '0;
                            r_cnt      <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Dividend bits shift out the top while quotient bits
                    // shift in at the bottom of the same register.
                    r_p   <= w_p_next;
                    r_dvd <= {r_dvd[2*W-2:0], w_qbit};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_q     <= {r_dvd[W-2:0], w_qbit};
                        r_r     <= w_p_next;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.q        = r_q;
    assign bus.r        = r_r;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.ovf      = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Scoreboard bench for seq_restoring_divider, directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_done   = 0;
    exp_t sb[$];

    seq_restoring_divider_if #(.W(W)) bus ();

    seq_restoring_divider #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus.done === 1'b1) begin
            n_done++;
            check("done_busy_excl", {31'd0, bus.busy}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
            end else begin
                e = sb.pop_front();
                check("q", {16'd0, bus.q}, {16'd0, e.q});
                check("r", {16'd0, bus.r}, {16'd0, e.r});
                check("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
                check("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic edz, input logic eovf, input int acc_cyc);
        exp_t e;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.ovf = eovf;
        e.cyc = acc_cyc + ((edz || eovf) ? 1 : 2*W+1);
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eovf);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        @(posedge clk);
        #1;
        push_exp(eq, er, edz, eovf, cyc);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = W'($urandom);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d pending ops expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q"}, {16'd0, bus.q}, 32'd0);
        check({tag, "_r"}, {16'd0, bus.r}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_div_zero"}, {31'd0, bus.div_zero}, 32'd0);
        check({tag, "_ovf"}, {31'd0, bus.ovf}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Product round-trip and small/back-to-back operations
        issue(32'h0EFC6FF4, 16'hF003, 16'h0FFC, 16'h0000, 1'b0, 1'b0);
        wait_idle(100);
        issue(32'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 1'b0);
        wait_idle(100);
        issue(32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        wait_idle(100);

        // Divide by zero: busy must stay low throughout
        issue(32'h0EFC6FF4, 16'h0000, 16'hFFFF, 16'h6FF4, 1'b1, 1'b0);
        check("dz_busy0", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check("dz_busy1", {31'd0, bus.busy}, 32'd0);
        wait_idle(20);

        // Overflow, then a normal op clears the flag
        issue(32'h00010000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        wait_idle(20);
        issue(32'h00001234, 16'h0010, 16'h0123, 16'h0004, 1'b0, 1'b0);
        wait_idle(100);

        // start pulsed mid-RUN with different operands is ignored
        issue(32'h0000FFFF, 16'h0100, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1;
        bus.divisor  = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(100);

        // start held from acceptance through FIN: exactly one operation
        d0 = n_done;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 16'd10;
        @(posedge clk);
        #1;
        push_exp(16'h0064, 16'h0000, 1'b0, 1'b0, cyc);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) break;
        end
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check("held_start_ops", n_done - d0, 32'd1);

        // Same for the two-cycle divide-by-zero path
        d0 = n_done;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'h0EFC6FF4;
        bus.divisor  = 16'h0000;
        @(posedge clk);
        #1;
        push_exp(16'hFFFF, 16'h6FF4, 1'b1, 1'b0, cyc);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("held_start_dz_ops", n_done - d0, 32'd1);
        wait_idle(5);

        // Reset mid-operation aborts with no done pulse
        issue(32'h0EFC6FF4, 16'hF003, 16'h0FFC, 16'h0000, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        repeat (40) @(posedge clk);
        #2;
        check("abort_no_done", n_done - d0, 32'd0);

        // Fresh operation after reset
        issue(32'd50000, 16'd300, 16'h00A6, 16'h00C8, 1'b0, 1'b0);
        wait_idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse partner of the 16x16 vedic multiplier: it takes a 2W-bit dividend (typically a multiplier product) and a W-bit divisor, and returns a W-bit quotient and a W-bit remainder.
- Used in the complex-multiplier datapath for normalisation and for self-checking product round-trips (product / b == a).
- One quotient bit is produced per clock, under a start/busy/done handshake.

Parameters:
- W, 16, operand width. Dividend is 2W bits; divisor, quotient and remainder are W bits each.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  2W  unsigned dividend; sampled with start
- divisor  input  W  unsigned divisor; sampled with start
- q  output  W  quotient; held until the next accepted start
- r  output  W  remainder; held until the next accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; q, r and flags are valid from this cycle on
- div_zero  output  1  divisor was 0 for the last operation; held
- ovf  output  1  quotient did not fit in W bits for the last operation; held

Behaviour:
- Reset: on a clk edge with rst=1, all outputs go to 0 (q, r, busy, done, div_zero, ovf), the state goes to IDLE and the counter goes to 0.
  - rst has priority over every other input.
  - rst mid-operation aborts the operation with no done pulse.
- Clocking: single clock domain; all registers are synchronous.
- FSM states: IDLE, RUN, FIN.
- IDLE: if start=1 at edge N, latch dividend and divisor, then pick one of three cases by priority:
  - divisor==0 → go to FIN. q=all ones, r=dividend[W-1:0], div_zero=1, ovf=0.
  - else if dividend[2W-1:W] >= divisor → go to FIN. q=all ones, r=0, ovf=1, div_zero=0.
  - else → go to RUN. Clear div_zero and ovf, set partial remainder P(W+1 bits)=0, counter=0, busy=1.
- RUN: one iteration per edge, MSB of the dividend first.
  - P = {P[W-1:0], next dividend bit}.
  - If P >= {1'b0,divisor}: P = P - divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - The quotient is shifted in LSB-side.
  - After exactly 2W iterations (the counter counts 0..2W-1), go to FIN. The upper W quotient bits are known to be 0 because ovf was excluded.
  - Only the low W bits are committed to q; r = P[W-1:0].
- FIN: lasts one cycle. done=1, busy=0, then unconditionally go to IDLE.
  - start during FIN is ignored; it must be re-asserted in IDLE.
- Latency:
  - Normal operation: start accepted at edge N, busy high from after N through edge N+2W, done high in the cycle after edge N+2W+1. That is 2W+2 cycles from start to done (34 for W=16).
  - Div-zero or overflow: done in the cycle after edge N+1.
- start while busy=1 is ignored. The operands are not re-sampled and the result is unaffected.
- The dividend and divisor inputs may change freely after acceptance.
- done is never high in the same cycle as busy.
- Arithmetic is unsigned only. The compare/subtract uses W+1 bits so that a carry out of P is never lost.

Test Plan:
- Round-trip: dividend=32'h0EFC6FF4 (16'h0FFC*16'hF003), divisor=16'hF003 → done after 34 cycles, q=16'h0FFC, r=0, ovf=0, div_zero=0.
- Small values and back-to-back: 32'd100 / 16'd7 → q=16'h000E, r=16'h0002. Start again in the first IDLE cycle after done with 32'hFFFE0001 / 16'hFFFF → q=16'hFFFF, r=0.
- Divide by zero: dividend=32'h0EFC6FF4, divisor=0 → done 2 cycles after start, div_zero=1, q=16'hFFFF, r=16'h6FF4, busy never high.
- Overflow: 32'h00010000 / 16'h0001 → ovf=1, q=16'hFFFF, r=0, done 2 cycles after start. A following normal operation clears ovf.
- start pulsed mid-RUN with different operands → ignored; the original result is delivered on schedule. start held high through FIN → exactly one operation per IDLE acceptance.
- rst asserted at iteration 10 → next cycle all outputs are 0 and no done pulse appears. A fresh start after rst drops produces a correct result.
